// File: rtl/nn_input_framer.sv
// Sliding-window framer: collects WIN samples, presents them to the network,
// then slides the window by HOP new samples for every subsequent frame.
module nn_input_framer #(
    parameter int DATA_W = 9,
    parameter int WIN    = 36,
    parameter int HOP    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [WIN*DATA_W-1:0] win_data,
    output logic [15:0]           frame_cnt
);

    localparam int FILL_W = $clog2(WIN + 1);
    localparam int HOP_W  = $clog2(HOP + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIN);
    localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP);

    localparam logic [1:0] ST_FILL    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_HOP     = 2'd2;

    logic [1:0]                   state_q;
    logic [1:0]                   state_d;
    logic [FILL_W-1:0]            fill_cnt;
    logic [FILL_W-1:0]            fill_d;
    logic [FILL_W-1:0]            fill_inc;
    logic [HOP_W-1:0]             hop_cnt;
    logic [HOP_W-1:0]             hop_d;
    logic [HOP_W-1:0]             hop_inc;
    logic [15:0]                  frame_q;
    logic [15:0]                  frame_d;
    logic [WIN-1:0][DATA_W-1:0]   win_q;
    logic [WIN-1:0][DATA_W-1:0]   win_d;
    logic [WIN-1:0][DATA_W-1:0]   win_shift;
    logic                         accept;

    assign s_ready   = (state_q != ST_PRESENT);
    assign win_valid = (state_q == ST_PRESENT);
    assign win_data  = win_q;
    assign frame_cnt = frame_q;
    assign accept    = s_valid && s_ready;

    // Oldest sample leaves at element 0, newest enters at element WIN-1.
    always_comb begin
        win_shift = win_q;
        for (int k = 0; k < WIN - 1; k++) begin
            win_shift[k] = win_q[k+1];
        end
        win_shift[WIN-1] = s_data;
    end

    // Counters hold at their limit instead of wrapping.
    always_comb begin
        fill_inc = (fill_cnt == FILL_LAST) ? fill_cnt : fill_cnt + FILL_W'(1);
        hop_inc  = (hop_cnt == HOP_LAST) ? hop_cnt : hop_cnt + HOP_W'(1);
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_cnt;
        hop_d   = hop_cnt;
        frame_d = frame_q;
        win_d   = win_q;
        if (clear) begin
            state_d = ST_FILL;
            fill_d  = '0;
            hop_d   = '0;
            frame_d = '0;
            win_d   = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        win_d  = win_shift;
                        fill_d = fill_inc;
                        if (fill_inc == FILL_LAST) begin
                            state_d = ST_PRESENT;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (win_ready) begin
                        state_d = ST_HOP;
                        hop_d   = '0;
                        frame_d = frame_q + 16'd1;
                    end
                end
                ST_HOP: begin
                    if (accept) begin
                        win_d = win_shift;
                        hop_d = hop_inc;
                        if (hop_inc == HOP_LAST) begin
                            state_d = ST_PRESENT;
                        end
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FILL;
            fill_cnt <= '0;
            hop_cnt  <= '0;
            frame_q  <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            fill_cnt <= fill_d;
            hop_cnt  <= hop_d;
            frame_q  <= frame_d;
            win_q    <= win_d;
        end
    end

endmodule

// File: tb/tb_nn_input_framer.sv
// Directed bench for nn_input_framer: default build plus HOP=1 and HOP=WIN builds.
module tb_nn_input_framer;

    localparam int DW = 9;
    localparam int W  = 36;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clear;
    logic            s_valid;
    logic            s_ready;
    logic [DW-1:0]   s_data;
    logic            win_valid;
    logic            win_ready;
    logic [W*DW-1:0] win_data;
    logic [15:0]     frame_cnt;

    logic            a_valid, a_ready, a_wvalid, a_wready;
    logic [DW-1:0]   a_data;
    logic [W*DW-1:0] a_wdata;
    logic [15:0]     a_frame;

    logic            b_valid, b_ready, b_wvalid, b_wready;
    logic [DW-1:0]   b_data;
    logic [W*DW-1:0] b_wdata;
    logic [15:0]     b_frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nn_input_framer #(.DATA_W(DW), .WIN(W), .HOP(12)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .frame_cnt(frame_cnt)
    );

    nn_input_framer #(.DATA_W(DW), .WIN(W), .HOP(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
        .win_valid(a_wvalid), .win_ready(a_wready), .win_data(a_wdata),
        .frame_cnt(a_frame)
    );

    nn_input_framer #(.DATA_W(DW), .WIN(W), .HOP(W)) u_hw (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .win_valid(b_wvalid), .win_ready(b_wready), .win_data(b_wdata),
        .frame_cnt(b_frame)
    );

    function automatic logic [DW-1:0] elem(input logic [W*DW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
        checks++; if (win_data !== '0) begin errors++; $display("FAIL reset_win_data: got %h expected 0", win_data); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [W*DW-1:0] snap;
        logic            all_ok;
        for (int i = 1; i <= W; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            tick();
            if (i == W - 1) begin
                checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL fill_early_valid: got %b expected 0", win_valid); end
            end
        end
        s_data = 9'h1FF;
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL fill_win_valid: got %b expected 1", win_valid); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready: got %b expected 0", s_ready); end
        checks++; if (elem(win_data, 0) !== 9'd1) begin errors++; $display("FAIL fill_elem0: got %0d expected 1", elem(win_data, 0)); end
        checks++; if (elem(win_data, W-1) !== 9'd36) begin errors++; $display("FAIL fill_elem35: got %0d expected 36", elem(win_data, W-1)); end
        all_ok = 1'b1;
        for (int k = 0; k < W; k++) if (elem(win_data, k) !== DW'(k + 1)) all_ok = 1'b0;
        checks++; if (!all_ok) begin errors++; $display("FAIL fill_order: got %h expected elements 1..36", win_data); end
        snap = win_data;
        for (int c = 0; c < 5; c++) tick();
        s_valid = 1'b0;
        checks++; if (win_data !== snap) begin errors++; $display("FAIL present_no_store: got %h expected %h", win_data, snap); end
    endtask

    task automatic test_hop();
        logic [W*DW-1:0] snap;
        logic            stable;
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL hop_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL hop_win_valid_low: got %b expected 0", win_valid); end
        for (int i = 37; i <= 48; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            tick();
            if (i == 47) begin
                checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL hop_early_valid: got %b expected 0", win_valid); end
            end
        end
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL hop_win_valid: got %b expected 1", win_valid); end
        checks++; if (elem(win_data, 0) !== 9'd13) begin errors++; $display("FAIL hop_elem0: got %0d expected 13", elem(win_data, 0)); end
        checks++; if (elem(win_data, W-1) !== 9'd48) begin errors++; $display("FAIL hop_elem35: got %0d expected 48", elem(win_data, W-1)); end
        snap   = win_data;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            s_data = DW'($urandom);
            tick();
            if (win_data !== snap || win_valid !== 1'b1) stable = 1'b0;
        end
        s_valid = 1'b0;
        checks++; if (!stable) begin errors++; $display("FAIL hop_hold_stable: got %h expected %h", win_data, snap); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL hop_frame_hold: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_gaps();
        int accepts;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        accepts = 0;
        for (int cyc = 0; cyc < 200 && win_valid !== 1'b1; cyc++) begin
            s_valid = (cyc % 2 == 0);
            s_data  = DW'(100 + accepts);
            tick();
            if (s_valid) accepts++;
        end
        s_valid = 1'b0;
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL gaps_win_valid: got %b expected 1 within 200 cycles", win_valid); end
        checks++; if (accepts !== 36) begin errors++; $display("FAIL gaps_accepts: got %0d expected 36", accepts); end
        checks++; if (elem(win_data, 0) !== 9'd100) begin errors++; $display("FAIL gaps_elem0: got %0d expected 100", elem(win_data, 0)); end
        checks++; if (elem(win_data, W-1) !== 9'd135) begin errors++; $display("FAIL gaps_elem35: got %0d expected 135", elem(win_data, W-1)); end
    endtask

    task automatic test_clear();
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(200 + i);
            tick();
        end
        s_data = 9'd205;
        clear  = 1'b1;
        tick();
        clear   = 1'b0;
        s_valid = 1'b0;
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL clear_win_valid: got %b expected 0", win_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL clear_s_ready: got %b expected 1", s_ready); end
        checks++; if (win_data !== '0) begin errors++; $display("FAIL clear_win_data: got %h expected 0", win_data); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL clear_frame_cnt: got %0d expected 0", frame_cnt); end
        for (int i = 0; i < W; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(300 + i);
            tick();
            if (i == W - 2) begin
                checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL clear_early_valid: got %b expected 0", win_valid); end
            end
        end
        s_valid = 1'b0;
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL clear_refill_valid: got %b expected 1", win_valid); end
        checks++; if (elem(win_data, 0) !== 9'd300) begin errors++; $display("FAIL clear_elem0: got %0d expected 300", elem(win_data, 0)); end
        checks++; if (elem(win_data, W-1) !== 9'd335) begin errors++; $display("FAIL clear_elem35: got %0d expected 335", elem(win_data, W-1)); end
    endtask

    task automatic test_async_reset();
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(400 + i);
            tick();
        end
        s_valid = 1'b0;
        checks++; if (win_valid !== 1'b1 || frame_cnt !== 16'd1) begin errors++; $display("FAIL areset_precond: got valid %b frame %0d expected 1 and 1", win_valid, frame_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (win_valid !== 1'b0) begin errors++; $display("FAIL areset_win_valid: got %b expected 0", win_valid); end
        checks++; if (win_data !== '0) begin errors++; $display("FAIL areset_win_data: got %h expected 0", win_data); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL areset_s_ready: got %b expected 1", s_ready); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL areset_frame_cnt: got %0d expected 0", frame_cnt); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_frame_wrap();
        for (int i = 0; i < W; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            tick();
        end
        s_valid = 1'b0;
        checks++; if (win_valid !== 1'b1) begin errors++; $display("FAIL wrap_present: got %b expected 1", win_valid); end
        force dut.frame_q = 16'hFFFF;
        #1;
        release dut.frame_q;
        checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", frame_cnt); end
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_frame_cnt: got %h expected 0000", frame_cnt); end
    endtask

    task automatic test_hop_one();
        for (int i = 1; i <= W; i++) begin
            a_valid = 1'b1;
            a_data  = DW'(i);
            tick();
        end
        a_valid = 1'b0;
        checks++; if (a_wvalid !== 1'b1) begin errors++; $display("FAIL hop1_first_valid: got %b expected 1", a_wvalid); end
        for (int r = 0; r < 3; r++) begin
            a_wready = 1'b1;
            tick();
            a_wready = 1'b0;
            checks++; if (a_wvalid !== 1'b0) begin errors++; $display("FAIL hop1_valid_low_%0d: got %b expected 0", r, a_wvalid); end
            a_valid = 1'b1;
            a_data  = DW'(37 + r);
            tick();
            a_valid = 1'b0;
            checks++; if (a_wvalid !== 1'b1) begin errors++; $display("FAIL hop1_valid_%0d: got %b expected 1", r, a_wvalid); end
            checks++; if (elem(a_wdata, 0) !== DW'(2 + r) || elem(a_wdata, W-1) !== DW'(37 + r)) begin
                errors++; $display("FAIL hop1_window_%0d: got %0d..%0d expected %0d..%0d", r, elem(a_wdata, 0), elem(a_wdata, W-1), 2 + r, 37 + r);
            end
        end
        checks++; if (a_frame !== 16'd3) begin errors++; $display("FAIL hop1_frame_cnt: got %0d expected 3", a_frame); end
    endtask

    task automatic test_hop_win();
        for (int i = 1; i <= W; i++) begin
            b_valid = 1'b1;
            b_data  = DW'(i);
            tick();
        end
        b_valid = 1'b0;
        checks++; if (b_wvalid !== 1'b1) begin errors++; $display("FAIL hopw_first_valid: got %b expected 1", b_wvalid); end
        b_wready = 1'b1;
        tick();
        b_wready = 1'b0;
        for (int i = 37; i <= 72; i++) begin
            b_valid = 1'b1;
            b_data  = DW'(i);
            tick();
            if (i == 71) begin
                checks++; if (b_wvalid !== 1'b0) begin errors++; $display("FAIL hopw_early_valid: got %b expected 0", b_wvalid); end
            end
        end
        b_valid = 1'b0;
        checks++; if (b_wvalid !== 1'b1) begin errors++; $display("FAIL hopw_valid: got %b expected 1", b_wvalid); end
        checks++; if (elem(b_wdata, 0) !== 9'd37 || elem(b_wdata, W-1) !== 9'd72) begin
            errors++; $display("FAIL hopw_window: got %0d..%0d expected 37..72", elem(b_wdata, 0), elem(b_wdata, W-1));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clear     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        win_ready = 1'b0;
        a_valid   = 1'b0;
        a_data    = '0;
        a_wready  = 1'b0;
        b_valid   = 1'b0;
        b_data    = '0;
        b_wready  = 1'b0;
        test_reset();
        test_fill();
        test_hop();
        test_gaps();
        test_clear();
        test_async_reset();
        test_frame_wrap();
        test_hop_one();
        test_hop_win();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_input_framer.md
NN_INPUT_FRAMER -- requirements
Module: nn_input_framer

Interface
REQ-001 Parameter DATA_W, default 9: sample width; matches the first-layer input width of the network.
REQ-002 Parameter WIN, default 36: window length; equals the network input count.
REQ-003 Parameter HOP, default 12: new samples between successive windows; legal range 1..WIN.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 clear  input  1  synchronous flush to the empty state.
REQ-007 s_valid  input  1  upstream sample valid.
REQ-008 s_ready  output  1  framer accepts a sample this cycle.
REQ-009 s_data  input  DATA_W  upstream sample, raw bits, not reinterpreted.
REQ-010 win_valid  output  1  full window presented to the network.
REQ-011 win_ready  input  1  consumer has captured the network result for the current window.
REQ-012 win_data  output  WIN*DATA_W  window; element k occupies bits [k*DATA_W+DATA_W-1 : k*DATA_W]; element 0 is the oldest sample and drives network input 1; element WIN-1 is the newest and drives input WIN.
REQ-013 frame_cnt  output  16  number of windows consumed since reset or clear.

Function
REQ-014 Accept event = s_valid and s_ready in the same cycle; samples with s_ready low are not taken, and upstream holds them.
REQ-015 On accept, the window shifts by one: element k takes element k+1 for k < WIN-1, element WIN-1 takes s_data, and the old element 0 is discarded.
REQ-016 FSM states: FILL, PRESENT, HOP.
- FILL: s_ready=1, win_valid=0; fill_cnt increments per accept.
- FILL -> PRESENT: on the accept that brings fill_cnt to WIN.
REQ-017 PRESENT:
- s_ready=0, win_valid=1; win_data stable for the whole state.
- On win_ready=1: go to HOP, hop_cnt=0, frame_cnt+1.
REQ-018 HOP:
- s_ready=1, win_valid=0; hop_cnt increments per accept.
- HOP -> PRESENT: on the accept that brings hop_cnt to HOP.
REQ-019 Latency: win_valid rises in the cycle after the completing accept; first window after WIN accepts, each later window after HOP accepts.
REQ-020 The counter limits govern the transitions: fill_cnt saturates at WIN and hop_cnt saturates at HOP; there is no wrap.
REQ-021 frame_cnt wraps from 0xFFFF to 0x0000.
REQ-022 win_ready is ignored outside PRESENT; s_valid is ignored in PRESENT.
REQ-023 clear has priority over all events in the same cycle and produces, next cycle:
- state FILL;
- fill_cnt=0, hop_cnt=0;
- all window elements 0;
- frame_cnt=0.
REQ-024 An accept coinciding with clear is discarded.
REQ-025 The block is purely registered storage and control; it performs no arithmetic on sample data.

Reset
REQ-026 While rst_n=0, without waiting for a clock edge:
- state FILL, s_ready=1, win_valid=0;
- win_data all zeros, frame_cnt=0, fill_cnt=0, hop_cnt=0.
REQ-027 Deassertion of rst_n is synchronized externally; first accept is possible on the first rising edge with rst_n=1.
REQ-028 Reset mid-operation (any state, any counter value) returns to the REQ-026 state; the partial window is lost.

Verification
REQ-029 Fill: after reset, feed samples 1..36 with s_valid=1 continuously -> win_valid=1 in the cycle after the 36th accept; element 0=1, element 35=36; s_ready=0.
REQ-030 Hop: from REQ-029, pulse win_ready for 1 cycle, then feed 37..48 -> frame_cnt=1; win_valid=1 after the 12th accept; element 0=13, element 35=48; win_data unchanged while win_ready is held 0 for 20 cycles.
REQ-031 Backpressure/gaps: during FILL, toggle s_valid 1/0 every cycle -> exactly 36 accepts needed; s_data presented while s_ready=0 in PRESENT is never stored.
REQ-032 Clear: assert clear together with s_valid in HOP after 5 hop samples -> next cycle FILL, win_data=0, frame_cnt=0; the coincident sample is absent; a new window needs 36 accepts.
REQ-033 Async reset: drop rst_n mid-cycle in PRESENT -> win_valid=0 and win_data=0 before the next clock edge.
REQ-034 Corners:
- HOP=1 and HOP=WIN builds: window every 1 and every 36 accepts.
- Force frame_cnt to 0xFFFF; one win_ready in PRESENT -> frame_cnt=0x0000.
